// File: rtl/jtag_cmd_bridge.sv
// jtag_cmd_bridge: 6-byte frame decoder driving a 16-bit req/ack bus.
// Optional write-ack byte (0x06) enabled by defining JTAG_CMD_WACK_EN.
module jtag_cmd_bridge #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned ADDR_W  = 24
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [7:0]        iRxD_DATA,
  input  logic              iRxD_Ready,
  output logic [7:0]        oTxD_DATA,
  output logic              oTxD_Start,
  input  logic              iTxD_Done,
  output logic [ADDR_W-1:0] oADDR,
  output logic [15:0]       oWDATA,
  output logic              oWR,
  output logic              oRD,
  input  logic [15:0]       iRDATA,
  input  logic              iACK,
  output logic              oFrame_Err
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_RX,
    S_REQ,
    S_WAIT,
    S_TX_HI,
    S_GAP_HI,
    S_TX_LO,
    S_GAP_END,
    S_TX_ACK
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        rlo_q, rlo_d;
  logic              gap_q, gap_d;

  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [15:0]       owdata_q, owdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [7:0]        txd_q, txd_d;
  logic              txs_q, txs_d;
  logic              err_q, err_d;

  // State and datapath registers; reset clears request and TX at once.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= S_RX;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rlo_q    <= '0;
      gap_q    <= 1'b0;
      oaddr_q  <= '0;
      owdata_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      txd_q    <= '0;
      txs_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rlo_q    <= rlo_d;
      gap_q    <= gap_d;
      oaddr_q  <= oaddr_d;
      owdata_q <= owdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      txd_q    <= txd_d;
      txs_q    <= txs_d;
      err_q    <= err_d;
    end
  end

  // Next-state: frame assembly, bus request and byte transmit sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    is_rd_d  = is_rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rlo_d    = rlo_q;
    gap_d    = gap_q;
    oaddr_d  = oaddr_q;
    owdata_d = owdata_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    txd_d    = txd_q;
    txs_d    = txs_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_RX: begin
        if (iRxD_Ready) begin
          tcnt_d = '0;
          if (cnt_q == 3'd0) begin
            if (iRxD_DATA == OP_WR || iRxD_DATA == OP_RD) begin
              is_rd_d = (iRxD_DATA == OP_RD);
              cnt_d   = 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (cnt_q <= 3'd3) begin
            addr_d = {addr_q[ADDR_W-9:0], iRxD_DATA};
            cnt_d  = cnt_q + 3'd1;
          end else begin
            wdata_d = {wdata_q[7:0], iRxD_DATA};
            if (cnt_q == 3'd5) begin
              cnt_d   = 3'd0;
              state_d = S_REQ;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end else if (TIMEOUT > 0 && cnt_q != 3'd0) begin
          if (tcnt_q == TLAST) begin
            tcnt_d = '0;
            cnt_d  = 3'd0;
            err_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      S_REQ: begin
        oaddr_d  = addr_q;
        owdata_d = wdata_q;
        wr_d     = !is_rd_q;
        rd_d     = is_rd_q;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (iACK && (wr_q || rd_q)) begin
          wr_d = 1'b0;
          rd_d = 1'b0;
          if (rd_q) begin
            rlo_d   = iRDATA[7:0];
            txd_d   = iRDATA[15:8];
            txs_d   = 1'b1;
            state_d = S_TX_HI;
          end else begin
`ifdef JTAG_CMD_WACK_EN
            txd_d   = 8'h06;
            txs_d   = 1'b1;
            state_d = S_TX_ACK;
`else
            state_d = S_RX;
`endif
          end
        end
      end

      S_TX_HI: begin
        if (iTxD_Done) begin
          txs_d   = 1'b0;
          gap_d   = 1'b0;
          state_d = S_GAP_HI;
        end
      end

      S_GAP_HI: begin
        if (gap_q) begin
          txd_d   = rlo_q;
          txs_d   = 1'b1;
          state_d = S_TX_LO;
        end else begin
          gap_d = 1'b1;
        end
      end

      S_TX_LO, S_TX_ACK: begin
        if (iTxD_Done) begin
          txs_d   = 1'b0;
          gap_d   = 1'b0;
          state_d = S_GAP_END;
        end
      end

      S_GAP_END: begin
        if (gap_q) begin
          state_d = S_RX;
        end else begin
          gap_d = 1'b1;
        end
      end

      default: state_d = S_RX;
    endcase
  end

  assign oTxD_DATA  = txd_q;
  assign oTxD_Start = txs_q;
  assign oADDR      = oaddr_q;
  assign oWDATA     = owdata_q;
  assign oWR        = wr_q;
  assign oRD        = rd_q;
  assign oFrame_Err = err_q;

endmodule

// File: tb/tb_jtag_cmd_bridge.sv
// tb_jtag_cmd_bridge: random frames against a queue-based model.
// Bus responder and TX sink pop expectations independently of the host.
module tb_jtag_cmd_bridge;

  localparam int TO = 20;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [7:0]  iRxD_DATA = '0;
  logic        iRxD_Ready = 1'b0;
  logic [7:0]  oTxD_DATA;
  logic        oTxD_Start;
  logic        iTxD_Done = 1'b0;
  logic [23:0] oADDR;
  logic [15:0] oWDATA;
  logic        oWR;
  logic        oRD;
  logic [15:0] iRDATA = '0;
  logic        iACK = 1'b0;
  logic        oFrame_Err;

  jtag_cmd_bridge #(.TIMEOUT(TO), .ADDR_W(24)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iRxD_DATA(iRxD_DATA), .iRxD_Ready(iRxD_Ready),
    .oTxD_DATA(oTxD_DATA), .oTxD_Start(oTxD_Start),
    .iTxD_Done(iTxD_Done),
    .oADDR(oADDR), .oWDATA(oWDATA),
    .oWR(oWR), .oRD(oRD),
    .iRDATA(iRDATA), .iACK(iACK),
    .oFrame_Err(oFrame_Err)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int         exp_err = 0;
  int         checks = 0;
  int         errors = 0;
  bit         bus_busy = 0;
  bit         tx_busy = 0;
  int         ack_force = -1;
  int         done_force = -1;
  bit         rd_force_en = 0;
  logic [15:0] rd_force = '0;

  function automatic void chk(bit ok, string name,
                              logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Bus responder: checks each request, then acks after a delay.
  initial begin : bus_resp
    req_t        r;
    int          d;
    bit          ab;
    bit          wk;
    logic [15:0] rv;
    forever begin
      @(posedge iCLK); #1;
      if (iRST_n && (oWR || oRD)) begin
        bus_busy = 1;
        chk(exp_bus.size() != 0, "bus_unexpected", {oWR, oRD}, 0);
        if (exp_bus.size() != 0) begin
          r = exp_bus.pop_front();
          chk(oWR == r.wr && oRD == !r.wr, "bus_kind",
              {oWR, oRD}, {r.wr, !r.wr});
          chk(oADDR == r.addr, "bus_addr", oADDR, r.addr);
          if (r.wr) chk(oWDATA == r.wdata, "bus_wdata", oWDATA, r.wdata);
        end
        d  = (ack_force >= 0) ? ack_force : $urandom_range(0, 4);
        ab = 0;
        for (int i = 0; i < d; i++) begin
          @(posedge iCLK); #1;
          if (!iRST_n) begin
            ab = 1;
            break;
          end
        end
        if (!ab) begin
          chk(oWR || oRD, "req_held", {oWR, oRD}, 1);
          wk = oWR;
          rv = rd_force_en ? rd_force : 16'($urandom);
          if (!wk) begin
            exp_tx.push_back(rv[15:8]);
            exp_tx.push_back(rv[7:0]);
          end
`ifdef JTAG_CMD_WACK_EN
          else exp_tx.push_back(8'h06);
`endif
          iRDATA = rv;
          iACK = 1'b1;
          @(posedge iCLK); #1;
          iACK = 1'b0;
          chk(!oWR && !oRD, "req_drop", {oWR, oRD}, 0);
        end
        bus_busy = 0;
      end
    end
  end

  // TX sink: checks byte, stability while Start is high and the gap.
  initial begin : tx_sink
    logic [7:0] b;
    logic [7:0] e;
    int         d;
    int         gap;
    bit         stable;
    forever begin
      @(posedge iCLK); #1;
      if (iRST_n && oTxD_Start) begin
        tx_busy = 1;
        b = oTxD_DATA;
        chk(exp_tx.size() != 0, "tx_unexpected", b, 0);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          chk(b == e, "tx_byte", b, e);
        end
        d = (done_force >= 0) ? done_force : $urandom_range(0, 5);
        stable = 1;
        for (int i = 0; i < d; i++) begin
          @(posedge iCLK); #1;
          if (!oTxD_Start || oTxD_DATA != b) stable = 0;
        end
        chk(stable, "tx_stable", oTxD_DATA, b);
        iTxD_Done = 1'b1;
        @(posedge iCLK); #1;
        iTxD_Done = 1'b0;
        chk(!oTxD_Start, "tx_start_drop", oTxD_Start, 0);
        if (exp_tx.size() != 0) begin
          gap = 0;
          while (!oTxD_Start && gap < 50) begin
            gap++;
            @(posedge iCLK); #1;
          end
          chk(gap == 2, "tx_gap", gap, 2);
        end
        tx_busy = 0;
      end
    end
  end

  // Error monitor: every pulse must be expected.
  initial begin : err_mon
    forever begin
      @(posedge iCLK); #1;
      if (iRST_n && oFrame_Err) begin
        chk(exp_err > 0, "err_unexpected", exp_err, 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge iCLK);
    iRxD_DATA  = b;
    iRxD_Ready = 1'b1;
    @(negedge iCLK);
    iRxD_Ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op,
                            input logic [23:0] a,
                            input logic [15:0] d);
    req_t r;
    logic [7:0] fb[6];
    if (op == 8'h57 || op == 8'h52) begin
      r.wr = (op == 8'h57);
      r.addr = a;
      r.wdata = d;
      exp_bus.push_back(r);
      fb = '{op, a[23:16], a[15:8], a[7:0], d[15:8], d[7:0]};
      for (int i = 0; i < 6; i++) begin
        send_byte(fb[i]);
        repeat ($urandom_range(0, 3)) @(negedge iCLK);
      end
    end else begin
      exp_err++;
      send_byte(op);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_bus.size() == 0 && exp_tx.size() == 0 &&
             exp_err == 0 && !bus_busy && !tx_busy &&
             !oWR && !oRD && !oTxD_Start) && n < 3000) begin
      @(posedge iCLK);
      n++;
    end
    chk(n < 3000, "idle_timeout", n, 3000);
    repeat (4) @(posedge iCLK);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : host
    int first;
    int n;
    logic [7:0] op;
    int sel;

    repeat (3) @(posedge iCLK);
    #1;
    chk(oWR == 0, "rst_wr", oWR, 0);
    chk(oRD == 0, "rst_rd", oRD, 0);
    chk(oTxD_Start == 0, "rst_txs", oTxD_Start, 0);
    chk(oTxD_DATA == 0, "rst_txd", oTxD_DATA, 0);
    chk(oADDR == 0, "rst_addr", oADDR, 0);
    chk(oWDATA == 0, "rst_wdata", oWDATA, 0);
    chk(oFrame_Err == 0, "rst_err", oFrame_Err, 0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);

    ack_force = 3;
    send_frame(8'h57, 24'h123456, 16'hABCD);
    wait_idle();
    ack_force = -1;

    rd_force_en = 1;
    rd_force = 16'hBEEF;
    send_frame(8'h52, 24'h000010, 16'h0000);
    wait_idle();

    send_frame(8'h41, 24'h0, 16'h0);
    send_frame(8'h57, 24'hC0FFEE, 16'h1234);
    wait_idle();

    exp_err++;
    send_byte(8'h57);
    send_byte(8'h12);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge iCLK); #1;
      if (oFrame_Err && first == 0) first = k;
    end
    chk(first == TO, "timeout_cycle", first, TO);
    send_frame(8'h52, 24'hA5A5A5, 16'h0);
    wait_idle();

    ack_force = 0;
    done_force = 100;
    rd_force = 16'hBEEF;
    send_frame(8'h52, 24'h000020, 16'h0);
    n = 0;
    while (!oTxD_Start && n < 100) begin
      @(posedge iCLK);
      n++;
    end
    chk(n < 100, "tx_start_wait", n, 100);
    send_byte(8'h41);
    send_byte(8'h57);
    send_byte(8'h52);
    wait_idle();
    done_force = -1;
    rd_force_en = 0;

    ack_force = 1000;
    send_frame(8'h52, 24'h00BEEF, 16'h0);
    n = 0;
    while (!oRD && n < 100) begin
      @(posedge iCLK);
      n++;
    end
    chk(n < 100, "rd_wait", n, 100);
    repeat (2) @(posedge iCLK);
    #2;
    iRST_n = 1'b0;
    #1;
    chk(!oRD, "rst_async_rd", oRD, 0);
    chk(!oTxD_Start, "rst_async_txs", oTxD_Start, 0);
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    ack_force = -1;
    n = 0;
    while (bus_busy && n < 100) begin
      @(posedge iCLK);
      n++;
    end
    chk(n < 100, "resp_abort", n, 100);
    send_frame(8'h57, 24'h654321, 16'h5AA5);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) op = 8'h57;
      else if (sel < 8) op = 8'h52;
      else op = 8'($urandom);
      send_frame(op, 24'($urandom), 16'($urandom));
      wait_idle();
    end

    chk(exp_bus.size() == 0, "bus_left", exp_bus.size(), 0);
    chk(exp_tx.size() == 0, "tx_left", exp_tx.size(), 0);
    chk(exp_err == 0, "err_left", exp_err, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_bridge.md
Name: jtag_cmd_bridge

Overview:
- Command decoder directly downstream of the USB-JTAG byte link, in the iCLK domain.
- Assembles received bytes into fixed 6-byte command frames and executes each as a 16-bit read or write on a simple request/acknowledge bus.
- For reads, returns the result to the host as two bytes through the link's transmit start/done handshake.

Parameters:
- TIMEOUT, 1000000: inter-byte timeout in iCLK cycles while a frame is partially received; 0 disables the timeout.
- ADDR_W, 24: bus address width, fixed at 24 because the frame carries three address bytes; other values are unsupported.

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iRxD_DATA  in  8  received byte; valid only in the cycle iRxD_Ready is high.
- iRxD_Ready  in  1  one-cycle pulse, one per received byte.
- oTxD_DATA  out  8  byte to transmit.
- oTxD_Start  out  1  held high while a byte is being transmitted.
- iTxD_Done  in  1  one-cycle pulse when the current byte has been sent.
- oADDR  out  24  bus address.
- oWDATA  out  16  bus write data.
- oWR  out  1  write request, level.
- oRD  out  1  read request, level.
- iRDATA  in  16  read data; valid in the cycle iACK is high.
- iACK  in  1  bus acknowledge, one-cycle pulse.
- oFrame_Err  out  1  one-cycle pulse on a bad opcode or a timeout.

Behaviour:
- Clock and reset: one clock, iCLK. iRST_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, byte counter 0, timeout counter 0.
- Frame format, MSB first: OP, A[23:16], A[15:8], A[7:0], D[15:8], D[7:0]. All 6 bytes are always sent; D is ignored for reads.
- Opcodes: 0x57 ('W') is a write. 0x52 ('R') is a read.
- State RX: a byte counter 0..5 advances on each iRxD_Ready.
  - Byte 0 is checked immediately. Any value other than 0x57 or 0x52 pulses oFrame_Err the next cycle, the byte is discarded and the counter stays 0.
  - Bytes 1-3 are shifted into the address register; bytes 4-5 into the write-data register.
  - On byte 5 the counter returns to 0 and the state moves to REQ the next cycle.
- Timeout: while the counter is nonzero, a timeout counter increments every cycle without iRxD_Ready and clears on iRxD_Ready. When it reaches TIMEOUT (TIMEOUT > 0), the partial frame is dropped, oFrame_Err pulses once and the state returns to RX with the counter at 0.
- State REQ: oADDR and oWDATA are driven from the frame registers; oWR or oRD goes high and is held in state WAIT.
- State WAIT:
  - iACK is sampled only while the request is high. On iACK, the request drops the next cycle.
  - For reads, iRDATA is captured in the iACK cycle.
  - An iACK in the first cycle the request is high is legal.
  - A read goes to TX_HI; a write goes to RX (or TX_ACK, see the optional feature).
  - There is no bus timeout: WAIT holds until iACK.
- State TX_HI: oTxD_DATA = rdata[15:8] and oTxD_Start = 1, held until iTxD_Done. Then oTxD_Start = 0 for exactly 2 cycles (state TX_GAP), then TX_LO.
- State TX_LO: same rule with rdata[7:0]. After iTxD_Done and a 2-cycle gap, return to RX.
- oTxD_DATA is stable for the whole time oTxD_Start is high.
- Bytes arriving on iRxD_Ready outside RX (REQ, WAIT, TX states) are dropped and have no effect. The link suppresses receive-ready while transmitting; any bytes that still arrive are dropped.
- iTxD_Done outside a TX state is ignored.
- A reset mid-transaction drops the request, TX start and frame immediately, asynchronously.

Optional Feature:
- Macro: JTAG_CMD_WACK_EN.
- When defined: after a write's iACK, state TX_ACK sends one byte 0x06 with the same start/done/2-cycle-gap rules, then returns to RX.
- When undefined: writes return directly to RX and produce no transmit traffic.

Test Plan:
- Write: bytes 57 12 34 56 AB CD -> oWR high with oADDR=0x123456 and oWDATA=0xABCD; iACK after 3 cycles -> oWR low the next cycle, no oTxD_Start (0x06 byte sent if JTAG_CMD_WACK_EN).
- Read: bytes 52 00 00 10 00 00, iACK with iRDATA=0xBEEF -> oRD at oADDR=0x000010; then TX 0xBE; after Done, exactly 2 low cycles; then TX 0xEF; state returns to RX.
- Bad opcode 0x41 followed by a valid write frame -> one oFrame_Err pulse, then the write executes normally.
- TIMEOUT=20; send 57 12 then stall 25 cycles -> oFrame_Err at cycle 20; a subsequent full read frame works.
- Read with iACK in the first request cycle and iTxD_Done held off for 100 cycles -> oTxD_DATA stays 0xBE and oTxD_Start stays high throughout; extra iRxD_Ready bytes during TX are ignored.
- Assert iRST_n low during WAIT -> oRD and oTxD_Start low immediately; a new frame after reset executes normally.
